// File: rtl/fpga_template_pkg.sv
// Shared defaults and capture FSM state encoding for the I2S capture array.
package fpga_template_pkg;

  localparam int unsigned N_LINES_DEF  = 2;
  localparam int unsigned SAMPLE_W_DEF = 24;
  localparam int unsigned SLOT_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } cap_state_e;

endpackage

// File: rtl/i2s_line_shifter.sv
// Per-line I2S shift register with left/right hold registers.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : discard shift and hold contents (partial frame drop)
//   shift_i       : shift sd_i in, MSB first
//   last_i        : this shift completes the word; latch it into a hold register
//   side_i        : 0 = left hold, 1 = right hold
//   sd_i          : synchronised serial data bit
//   left_o/right_o: held words
module i2s_line_shifter
  import fpga_template_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                shift_i,
  input  logic                last_i,
  input  logic                side_i,
  input  logic                sd_i,
  output logic [SAMPLE_W-1:0] left_o,
  output logic [SAMPLE_W-1:0] right_o
);

  logic [SAMPLE_W-1:0] sr_q;
  logic [SAMPLE_W-1:0] sr_d;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;

  assign sr_d = {sr_q[SAMPLE_W-2:0], sd_i};

  // Hold register captures the completed word on the same edge as its last bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q    <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else if (clr_i) begin
      sr_q    <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else if (shift_i) begin
      sr_q <= sr_d;
      if (last_i) begin
        if (side_i) right_q <= sr_d;
        else        left_q  <= sr_d;
      end
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;

endmodule

// File: rtl/i2s_capture_array.sv
// Multi-line I2S receiver: synchronises SCK/WS/SD into clk_i, aligns on WS,
// captures stereo words per line and presents whole frames on a valid/ready
// interface with sticky overrun and sync-error flags.
// Ports:
//   clk_i, rst_ni            : system clock, async active-low reset
//   sck_i, ws_i, sd_i        : I2S bit clock, word select, per-line data
//   en_i                     : per-channel enable (channel = 2*line + side)
//   clr_i                    : clears sticky flags
//   samples_o                : frame payload, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   frame_valid_o/ready_i    : frame handshake
//   frame_cnt_o              : committed frame count (wraps)
//   overrun_o, sync_err_o    : sticky status flags
module i2s_capture_array
  import fpga_template_pkg::*;
#(
  parameter int unsigned N_LINES  = N_LINES_DEF,
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned SLOT_W   = SLOT_W_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            sck_i,
  input  logic                            ws_i,
  input  logic [N_LINES-1:0]              sd_i,
  input  logic [2*N_LINES-1:0]            en_i,
  input  logic                            clr_i,
  output logic [2*N_LINES*SAMPLE_W-1:0]   samples_o,
  output logic                            frame_valid_o,
  input  logic                            frame_ready_i,
  output logic [15:0]                     frame_cnt_o,
  output logic                            overrun_o,
  output logic                            sync_err_o
);

  localparam int unsigned CNT_W   = $clog2(SLOT_W + 1);
  localparam int unsigned FRAME_W = 2 * N_LINES * SAMPLE_W;

  // Input synchronisers plus previous-SCK flop for edge detection.
  logic [1:0]         sck_sync_q;
  logic [1:0]         ws_sync_q;
  logic [N_LINES-1:0] sd_meta_q;
  logic [N_LINES-1:0] sd_sync_q;
  logic               sck_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_meta_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], sck_i};
      ws_sync_q  <= {ws_sync_q[0], ws_i};
      sd_meta_q  <= sd_i;
      sd_sync_q  <= sd_meta_q;
      sck_prev_q <= sck_sync_q[1];
    end
  end

  logic sck_rise;
  logic ws_s;
  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign ws_s     = ws_sync_q[1];

  // Capture FSM state.
  cap_state_e       state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             ws_prev_q;
  logic             done_r_q;

  logic ws_fell;
  logic ws_chg;
  logic in_slot;
  logic short_slot;
  logic shift_en;
  logic last_bit;
  logic side_right;
  logic sync_hit;

  // Datapath strobes; the bit seen on a WS change is the I2S delay bit and is dropped.
  always_comb begin
    ws_fell    = ws_prev_q & ~ws_s;
    ws_chg     = ws_prev_q ^ ws_s;
    in_slot    = (state_q != ST_ALIGN);
    short_slot = (bit_cnt_q < CNT_W'(SAMPLE_W));
    last_bit   = (bit_cnt_q == CNT_W'(SAMPLE_W - 1));
    side_right = (state_q == ST_RIGHT);
    shift_en   = sck_rise & in_slot & ~ws_chg & short_slot;
    sync_hit   = sck_rise & in_slot & ws_chg & short_slot;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_ALIGN;
      bit_cnt_q <= '0;
      ws_prev_q <= 1'b0;
      done_r_q  <= 1'b0;
    end else begin
      done_r_q <= shift_en & last_bit & side_right;
      if (sck_rise) begin
        ws_prev_q <= ws_s;
        unique case (state_q)
          ST_ALIGN: begin
            if (ws_fell) begin
              state_q   <= ST_LEFT;
              bit_cnt_q <= '0;
            end
          end
          default: begin
            if (ws_chg) begin
              bit_cnt_q <= '0;
              if (short_slot) state_q <= ws_fell ? ST_LEFT : ST_ALIGN;
              else            state_q <= ws_s ? ST_RIGHT : ST_LEFT;
            end else if (bit_cnt_q < CNT_W'(SLOT_W)) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  logic [SAMPLE_W-1:0] left_w  [N_LINES];
  logic [SAMPLE_W-1:0] right_w [N_LINES];

  for (genvar l = 0; l < N_LINES; l++) begin : g_line
    i2s_line_shifter #(
      .SAMPLE_W (SAMPLE_W)
    ) u_shifter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (sync_hit),
      .shift_i (shift_en),
      .last_i  (last_bit),
      .side_i  (side_right),
      .sd_i    (sd_sync_q[l]),
      .left_o  (left_w[l]),
      .right_o (right_w[l])
    );
  end

  // Frame payload with disabled channels zeroed.
  logic [FRAME_W-1:0] frame_masked;

  always_comb begin
    frame_masked = '0;
    for (int l = 0; l < N_LINES; l++) begin
      if (en_i[2*l])   frame_masked[(2*l)*SAMPLE_W   +: SAMPLE_W] = left_w[l];
      if (en_i[2*l+1]) frame_masked[(2*l+1)*SAMPLE_W +: SAMPLE_W] = right_w[l];
    end
  end

  // Commit, handshake and sticky flags.
  logic [FRAME_W-1:0] samples_q;
  logic               valid_q;
  logic [15:0]        frame_cnt_q;
  logic               overrun_q;
  logic               sync_err_q;
  logic               commit;
  logic               ovr_set;

  assign commit  = done_r_q;
  assign ovr_set = commit & valid_q & ~frame_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samples_q   <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      if (commit) begin
        samples_q   <= frame_masked;
        valid_q     <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else if (valid_q && frame_ready_i) begin
        valid_q <= 1'b0;
      end
      overrun_q  <= ovr_set  | (overrun_q  & ~clr_i);
      sync_err_q <= sync_hit | (sync_err_q & ~clr_i);
    end
  end

  assign samples_o     = samples_q;
  assign frame_valid_o = valid_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign overrun_o     = overrun_q;
  assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_i2s_capture_array.sv
// Directed bench for i2s_capture_array: I2S frames driven at clk/sck = 16.
module tb_i2s_capture_array;

  localparam int unsigned N_LINES  = 2;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned SLOT_W   = 32;

  logic                          clk;
  logic                          rst_n;
  logic                          sck;
  logic                          ws;
  logic [N_LINES-1:0]            sd;
  logic [2*N_LINES-1:0]          en;
  logic                          clr;
  logic [2*N_LINES*SAMPLE_W-1:0] samples;
  logic                          frame_valid;
  logic                          frame_ready;
  logic [15:0]                   frame_cnt;
  logic                          overrun;
  logic                          sync_err;

  int n_checks = 0;
  int n_pass   = 0;

  time last_edge_t   = 0;
  time valid_rise_t  = 0;
  logic valid_prev   = 1'b0;

  i2s_capture_array #(
    .N_LINES  (N_LINES),
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sck_i         (sck),
    .ws_i          (ws),
    .sd_i          (sd),
    .en_i          (en),
    .clr_i         (clr),
    .samples_o     (samples),
    .frame_valid_o (frame_valid),
    .frame_ready_i (frame_ready),
    .frame_cnt_o   (frame_cnt),
    .overrun_o     (overrun),
    .sync_err_o    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timestamp the rising edge of frame_valid for the latency check.
  always @(negedge clk) begin
    if (frame_valid && !valid_prev) valid_rise_t <= $time;
    valid_prev <= frame_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [SAMPLE_W-1:0] ch(input int c);
    return samples[c*SAMPLE_W +: SAMPLE_W];
  endfunction

  // Slot bit 0 is the I2S delay bit, bits 1..24 carry MSB..LSB, the rest are padding.
  // Delay and padding bits are driven high so mis-captured positions show up.
  function automatic logic sd_bit(input logic [SAMPLE_W-1:0] w, input int k);
    if (k >= 1 && k <= SAMPLE_W) return w[SAMPLE_W-k];
    return 1'b1;
  endfunction

  task automatic send_slot(input logic ws_v, input logic [SAMPLE_W-1:0] w0,
                           input logic [SAMPLE_W-1:0] w1, input int first, input int nbits);
    for (int k = first; k < first + nbits; k++) begin
      sck   = 1'b0;
      ws    = ws_v;
      sd[0] = sd_bit(w0, k);
      sd[1] = sd_bit(w1, k);
      repeat (8) @(negedge clk);
      sck = 1'b1;
      if (ws_v && k == SAMPLE_W) last_edge_t = $time;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [SAMPLE_W-1:0] l0, input logic [SAMPLE_W-1:0] r0,
                            input logic [SAMPLE_W-1:0] l1, input logic [SAMPLE_W-1:0] r1);
    send_slot(1'b0, l0, l1, 0, SLOT_W);
    send_slot(1'b1, r0, r1, 0, SLOT_W);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    sck         = 1'b0;
    ws          = 1'b1;
    sd          = '0;
    en          = 4'b1111;
    clr         = 1'b0;
    frame_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset values
    check_eq("rst_samples", 64'(samples[63:0]), 64'h0);
    check_eq("rst_valid", 64'(frame_valid), 64'h0);
    check_eq("rst_cnt", 64'(frame_cnt), 64'h0);
    check_eq("rst_overrun", 64'(overrun), 64'h0);
    check_eq("rst_sync_err", 64'(sync_err), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, ready high
    send_slot(1'b1, '0, '0, 0, 2);
    send_frame(24'h123456, 24'hABCDEF, 24'h000001, 24'h800000);
    check_eq("basic_ch0", 64'(ch(0)), 64'h123456);
    check_eq("basic_ch1", 64'(ch(1)), 64'hABCDEF);
    check_eq("basic_ch2", 64'(ch(2)), 64'h000001);
    check_eq("basic_ch3", 64'(ch(3)), 64'h800000);
    check_eq("basic_cnt", 64'(frame_cnt), 64'd1);
    check_eq("basic_valid_cleared", 64'(frame_valid), 64'h0);
    check_eq("latency_le4", 64'((valid_rise_t > last_edge_t) && (valid_rise_t - last_edge_t <= 40)), 64'h1);

    // Channel enable mask
    en = 4'b0101;
    send_frame(24'h123456, 24'hABCDEF, 24'h000001, 24'h800000);
    check_eq("mask_ch0", 64'(ch(0)), 64'h123456);
    check_eq("mask_ch1", 64'(ch(1)), 64'h0);
    check_eq("mask_ch2", 64'(ch(2)), 64'h000001);
    check_eq("mask_ch3", 64'(ch(3)), 64'h0);
    check_eq("mask_cnt", 64'(frame_cnt), 64'd2);
    en = 4'b1111;

    // Overrun: three frames with ready low
    pulse_reset();
    frame_ready = 1'b0;
    send_slot(1'b1, '0, '0, 0, 2);
    send_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    check_eq("ovr_no_flag_first", 64'(overrun), 64'h0);
    send_frame(24'h555555, 24'h666666, 24'h777777, 24'h888888);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 24'h5A5A5A, 24'hA5A5A5);
    check_eq("ovr_valid", 64'(frame_valid), 64'h1);
    check_eq("ovr_ch0", 64'(ch(0)), 64'h0F0F0F);
    check_eq("ovr_ch1", 64'(ch(1)), 64'hF0F0F0);
    check_eq("ovr_ch2", 64'(ch(2)), 64'h5A5A5A);
    check_eq("ovr_ch3", 64'(ch(3)), 64'hA5A5A5);
    check_eq("ovr_flag", 64'(overrun), 64'h1);
    check_eq("ovr_cnt", 64'(frame_cnt), 64'd3);
    pulse_clr();
    check_eq("ovr_clr", 64'(overrun), 64'h0);
    check_eq("ovr_hold_ch1", 64'(ch(1)), 64'hF0F0F0);
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("accept_clears_valid", 64'(frame_valid), 64'h0);

    // Sync error: WS rises after only 10 left-slot data bits
    send_slot(1'b0, 24'hFFFFFF, 24'hFFFFFF, 0, 11);
    send_slot(1'b1, '0, '0, 0, 5);
    check_eq("serr_flag", 64'(sync_err), 64'h1);
    check_eq("serr_no_commit_cnt", 64'(frame_cnt), 64'd3);
    check_eq("serr_no_commit_valid", 64'(frame_valid), 64'h0);
    send_frame(24'hCAFE12, 24'h345678, 24'h9ABCDE, 24'h0000F0);
    check_eq("serr_next_cnt", 64'(frame_cnt), 64'd4);
    check_eq("serr_next_ch0", 64'(ch(0)), 64'hCAFE12);
    check_eq("serr_next_ch3", 64'(ch(3)), 64'h0000F0);
    pulse_clr();
    check_eq("serr_clr", 64'(sync_err), 64'h0);

    // Reset mid right slot
    send_slot(1'b0, 24'hAAAAAA, 24'hBBBBBB, 0, SLOT_W);
    send_slot(1'b1, 24'hCCCCCC, 24'hDDDDDD, 0, 15);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_samples", 64'(samples[63:0]), 64'h0);
    check_eq("midrst_samples_hi", 64'(samples[95:64]), 64'h0);
    check_eq("midrst_valid", 64'(frame_valid), 64'h0);
    check_eq("midrst_cnt", 64'(frame_cnt), 64'h0);
    check_eq("midrst_flags", 64'({overrun, sync_err}), 64'h0);
    rst_n = 1'b1;
    send_slot(1'b1, 24'hCCCCCC, 24'hDDDDDD, 15, SLOT_W - 15);
    check_eq("midrst_no_commit", 64'(frame_cnt), 64'h0);
    send_frame(24'h13579B, 24'h2468AC, 24'hFEDCBA, 24'h010203);
    check_eq("midrst_first_cnt", 64'(frame_cnt), 64'd1);
    check_eq("midrst_first_ch1", 64'(ch(1)), 64'h2468AC);
    check_eq("midrst_first_ch2", 64'(ch(2)), 64'hFEDCBA);

    // Frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    send_frame(24'h000002, 24'h000003, 24'h000004, 24'h000005);
    check_eq("wrap_cnt", 64'(frame_cnt), 64'h0000);
    check_eq("wrap_ch0", 64'(ch(0)), 64'h000002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
